// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and constants for the register-file write-back slice
package rf_pkg;

  localparam int RF_XLEN  = 64;
  localparam int RF_NREG  = 32;
  localparam int RF_IDX_W = 5;

  typedef logic [RF_IDX_W-1:0] rf_idx_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;

  typedef struct packed {
    logic               valid;
    rf_idx_t            rd;
    logic [RF_XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with a priority pointer
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_alu, req_lsu   requests
//   gnt_alu, gnt_lsu   same-cycle grants (at most one high, never without its request)
module rr_arb2
  import rf_pkg::*;
#(
  parameter bit LSU_FIRST = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_alu,
  input  logic req_lsu,
  output logic gnt_alu,
  output logic gnt_lsu
);

  req_e ptr;
  req_e ptr_next;

  always_comb begin
    gnt_alu  = req_alu & (~req_lsu | (ptr == REQ_ALU));
    gnt_lsu  = req_lsu & (~req_alu | (ptr == REQ_LSU));
    ptr_next = ptr;
    // Only a contested grant moves the pointer, and it moves to the loser.
    if (req_alu && req_lsu) begin
      ptr_next = (ptr == REQ_ALU) ? REQ_LSU : REQ_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= LSU_FIRST ? REQ_LSU : REQ_ALU;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// rtl/rf_wb_ctrl.sv - write-back arbiter, RF write port driver and pending-write scoreboard
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alu_valid/ready/rd/data       ALU write-back request
//   lsu_valid/ready/rd/data       LSU write-back request
//   issue_valid/ready/rd          decode reserving a destination register
//   rs1, rs2, rs1_busy, rs2_busy  decode source hazard lookup
//   reg_w_EN, rw, rw_data         registered RF write port
//   wb_err                        sticky: write-back to a register that was not pending
module rf_wb_ctrl
  import rf_pkg::*;
#(
  parameter int XLEN      = RF_XLEN,
  parameter int NREG      = RF_NREG,
  parameter bit LSU_FIRST = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            reg_w_EN,
  output logic [4:0]      rw,
  output logic [XLEN-1:0] rw_data,
  output logic            wb_err
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  logic            wb_fire;
  logic            wb_write;
  rf_idx_t         wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            issue_fire;

  rr_arb2 #(
    .LSU_FIRST(LSU_FIRST)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_alu (alu_valid),
    .req_lsu (lsu_valid),
    .gnt_alu (alu_ready),
    .gnt_lsu (lsu_ready)
  );

  always_comb begin
    wb_fire     = (alu_valid & alu_ready) | (lsu_valid & lsu_ready);
    wb_rd       = alu_ready ? alu_rd : lsu_rd;
    wb_data     = alu_ready ? alu_data : lsu_data;
    // x0 is accepted so the requester drains, but never written or tracked.
    wb_write    = wb_fire & (wb_rd != '0);

    issue_ready = (issue_rd == '0) | ~busy[issue_rd];
    issue_fire  = issue_valid & issue_ready;

    rs1_busy    = (rs1 != '0) & busy[rs1];
    rs2_busy    = (rs2 != '0) & busy[rs2];

    // Clear happens when the write-back is accepted, not when the RF is written.
    busy_next = busy;
    if (wb_write) begin
      busy_next[wb_rd] = 1'b0;
    end
    if (issue_fire && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      reg_w_EN <= 1'b0;
      rw       <= '0;
      rw_data  <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy     <= busy_next;
      reg_w_EN <= wb_write;
      if (wb_write) begin
        rw      <= wb_rd;
        rw_data <= wb_data;
      end
      if (wb_write && !busy[wb_rd]) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb/tb_rf_wb_ctrl.sv - self-checking bench for rf_wb_ctrl against a behavioural model
module tb_rf_wb_ctrl;

  localparam bit LSU_FIRST = 1'b0;

  logic        clk;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd, rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        reg_w_EN;
  logic [4:0]  rw;
  logic [63:0] rw_data;
  logic        wb_err;

  rf_wb_ctrl #(
    .XLEN(64), .NREG(32), .LSU_FIRST(LSU_FIRST)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .reg_w_EN(reg_w_EN), .rw(rw), .rw_data(rw_data), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a set of pending registers, who has priority next time
  // both units compete, the sticky error, and the write expected on the port.
  bit          m_pending[32];
  bit          m_lsu_prio;
  bit          m_err;
  bit          exp_wen;
  logic [4:0]  exp_rw;
  logic [63:0] exp_data;
  bit          was_rst;
  bit          last_ga, last_gl;

  task automatic idle();
    rst = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  // Checks the same-cycle outputs, advances one clock and the model,
  // then checks the registered outputs.
  task automatic cycle();
    bit ga, gl, ir;
    logic [4:0]  wrd;
    logic [63:0] wd;
    #1;
    ga = alu_valid && (!lsu_valid || !m_lsu_prio);
    gl = lsu_valid && (!alu_valid || m_lsu_prio);
    ir = (issue_rd == 0) || !m_pending[issue_rd];
    check("alu_ready", 64'(alu_ready), 64'(ga));
    check("lsu_ready", 64'(lsu_ready), 64'(gl));
    check("ready_onehot", 64'(alu_ready & lsu_ready), 64'(0));
    check("issue_ready", 64'(issue_ready), 64'(ir));
    check("rs1_busy", 64'(rs1_busy), 64'((rs1 != 0) && m_pending[rs1]));
    check("rs2_busy", 64'(rs2_busy), 64'((rs2 != 0) && m_pending[rs2]));
    last_ga = ga;
    last_gl = gl;
    @(posedge clk);
    if (rst) begin
      foreach (m_pending[i]) m_pending[i] = 0;
      m_lsu_prio = LSU_FIRST;
      m_err = 0;
      exp_wen = 0;
      exp_rw = 0;
      exp_data = 0;
      was_rst = 1;
    end else begin
      was_rst = 0;
      if (alu_valid && lsu_valid) m_lsu_prio = ga;
      wrd = ga ? alu_rd : lsu_rd;
      wd  = ga ? alu_data : lsu_data;
      exp_wen = 0;
      if ((ga || gl) && wrd != 0) begin
        if (!m_pending[wrd]) m_err = 1;
        m_pending[wrd] = 0;
        exp_wen = 1;
        exp_rw = wrd;
        exp_data = wd;
      end
      if (issue_valid && ir && issue_rd != 0) m_pending[issue_rd] = 1;
    end
    #1;
    check("reg_w_EN", 64'(reg_w_EN), 64'(exp_wen));
    check("wb_err", 64'(wb_err), 64'(m_err));
    if (exp_wen || was_rst) begin
      check("rw", 64'(rw), 64'(exp_rw));
      check("rw_data", rw_data, exp_data);
    end
  endtask

  bit alu_hold, lsu_hold;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1;
    cycle();
    cycle();
    check("rst_wen", 64'(reg_w_EN), 64'(0));
    check("rst_err", 64'(wb_err), 64'(0));

    // 1: single ALU write-back
    idle(); alu_valid = 1; alu_rd = 5; alu_data = 64'hDEAD;
    cycle();
    idle(); cycle();
    check("t1_rw", 64'(rw), 64'(5));
    check("t1_data", rw_data, 64'hDEAD);
    cycle();
    check("t1_wen_off", 64'(reg_w_EN), 64'(0));

    // 2: contention alternates ALU, LSU, ALU, LSU
    idle(); rst = 1; cycle();
    for (int i = 0; i < 4; i++) begin
      idle();
      alu_valid = 1; alu_rd = 3; alu_data = 64'(100 + i);
      lsu_valid = 1; lsu_rd = 4; lsu_data = 64'(200 + i);
      #1;
      check("t2_alu_gnt", 64'(alu_ready), 64'(i % 2 == 0));
      check("t2_lsu_gnt", 64'(lsu_ready), 64'(i % 2 == 1));
      cycle();
      check("t2_rw", 64'(rw), 64'((i % 2 == 0) ? 3 : 4));
    end

    // 3: reserve x7, block a second issue, clear by LSU write-back
    idle(); rst = 1; cycle();
    idle(); issue_valid = 1; issue_rd = 7; cycle();
    idle(); rs1 = 7; issue_valid = 1; issue_rd = 7; #1;
    check("t3_busy", 64'(rs1_busy), 64'(1));
    check("t3_blocked", 64'(issue_ready), 64'(0));
    cycle();
    idle(); rs1 = 7; lsu_valid = 1; lsu_rd = 7; lsu_data = 64'h77; cycle();
    idle(); rs1 = 7; issue_valid = 1; issue_rd = 7; #1;
    check("t3_cleared", 64'(rs1_busy), 64'(0));
    check("t3_reissue", 64'(issue_ready), 64'(1));
    check("t3_no_err", 64'(wb_err), 64'(0));
    cycle();

    // 4: x0 write-back drains but never writes
    idle(); rst = 1; cycle();
    idle(); lsu_valid = 1; lsu_rd = 0; lsu_data = 64'h1; rs1 = 0; cycle();
    idle(); cycle();
    check("t4_wen", 64'(reg_w_EN), 64'(0));
    check("t4_err", 64'(wb_err), 64'(0));

    // 5: write-back to a non-pending register sets a sticky error
    idle(); alu_valid = 1; alu_rd = 9; alu_data = 64'h99; cycle();
    check("t5_rw", 64'(rw), 64'(9));
    check("t5_err", 64'(wb_err), 64'(1));
    idle(); cycle(); cycle();
    check("t5_err_held", 64'(wb_err), 64'(1));

    // 6: reset beats an in-flight write-back
    idle(); issue_valid = 1; issue_rd = 12; cycle();
    idle(); alu_valid = 1; alu_rd = 12; alu_data = 64'hC; rst = 1; cycle();
    check("t6_wen", 64'(reg_w_EN), 64'(0));
    idle(); rs1 = 12; cycle();
    check("t6_wen_after", 64'(reg_w_EN), 64'(0));
    idle(); alu_valid = 1; lsu_valid = 1; alu_rd = 1; lsu_rd = 2; #1;
    check("t6_ptr", 64'(alu_ready), 64'(!LSU_FIRST));
    cycle();

    // Randomized traffic with held requests under backpressure
    idle(); rst = 1; cycle();
    alu_hold = 0; lsu_hold = 0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      if (!alu_hold) begin
        alu_valid = $urandom_range(0, 1);
        alu_rd = 5'($urandom_range(0, 7));
        alu_data = {$urandom, $urandom};
      end
      if (!lsu_hold) begin
        lsu_valid = $urandom_range(0, 1);
        lsu_rd = 5'($urandom_range(0, 7));
        lsu_data = {$urandom, $urandom};
      end
      issue_valid = $urandom_range(0, 1);
      issue_rd = 5'($urandom_range(0, 7));
      // Keep reservation and write-back targets apart in the same cycle.
      while (issue_rd != 0 && ((alu_valid && issue_rd == alu_rd) ||
                               (lsu_valid && issue_rd == lsu_rd)))
        issue_rd = 5'($urandom_range(1, 15));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      cycle();
      alu_hold = !rst && alu_valid && !last_ga;
      lsu_hold = !rst && lsu_valid && !last_gl;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
